uart_cmd_seq: RTL and testbench
===============================

Name: uart_cmd_seq

Overview:
- Command/response sequencer that sits between a UART transmitter/receiver pair and the design's host-side command logic.
- Assembles 3-byte command frames from the receive side: opcode, data high byte, data low byte.
- Presents each complete frame to the host through a valid/ack handshake.
- Returns the host's 16-bit response as two transmitted bytes, high byte first, then re-arms for the next frame.
- Aborts partial frames when the gap between bytes exceeds a timeout.

Parameters:
- TIMEOUT_CYC, 50000, maximum clk cycles allowed between consecutive bytes of one frame before the partial frame is discarded.
- TMR_W, 16, width of the inter-byte timer. Must satisfy 2^TMR_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rdy  in  1  UART receive byte available (level).
- rx_data  in  8  UART received byte, valid while rdy=1.
- clr_rdy  out  1  one-cycle pulse that consumes the received byte.
- trmt  out  1  one-cycle pulse that starts a UART transmit.
- tx_data  out  8  byte to transmit; held stable from trmt until completion.
- tx_done  in  1  UART transmit complete (level or pulse).
- cmd_vld  out  1  command frame available.
- cmd_op  out  8  opcode byte.
- cmd_data  out  16  {byte1, byte2}.
- cmd_ack  in  1  host accepts the command.
- resp_vld  in  1  host response valid; single-cycle sample.
- resp_data  in  16  response word.
- frm_err  out  1  one-cycle pulse on frame timeout.
- busy  out  1  high in every state except RX0.

Behaviour:
- Reset (rst=1, asynchronous):
  - State goes to RX0.
  - All outputs go to 0: clr_rdy, trmt, tx_data, cmd_vld, cmd_op, cmd_data, frm_err, busy.
  - Timer clears.
  - Reset mid-frame or mid-transmit discards everything; no resumption.
- States: RX0, RX1, RX2, CMD, RESP, TXH, WH, TXL, WL.
- Byte capture in RX0/RX1/RX2 (rdy=1 and no clr_rdy pending):
  - Latch rx_data into the slot for that state.
  - Pulse clr_rdy for exactly one cycle and advance state.
  - rdy is ignored during the cycle after clr_rdy. This guard prevents double capture while the UART clears rdy.
- CMD state:
  - Entered from RX2 with cmd_vld=1 starting the cycle after the third byte is captured (latency: 1 clk after capture).
  - cmd_vld, cmd_op and cmd_data stay stable until cmd_ack=1.
  - When cmd_ack=1 is sampled: cmd_vld drops the next cycle and the state moves to RESP.
- RESP state:
  - Waits for resp_vld=1, then latches resp_data.
  - resp_vld is ignored in every other state.
- TXH: tx_data=resp_data[15:8], trmt=1 for one cycle, then go to WH.
- WH:
  - Wait for a 0→1 transition of tx_done. Use edge detection, so a tx_done level still high from a prior byte is not treated as completion.
  - Then go to TXL.
- TXL / WL: same as TXH / WH with resp_data[7:0]; on completion return to RX0.
- tx_data holds its value until the next trmt.
- Timeout:
  - Timer clears on every byte capture.
  - Timer increments each cycle only in RX1 and RX2.
  - When the timer reaches TIMEOUT_CYC-1 with no byte arriving: return to RX0, pulse frm_err for one cycle, and drop the partial bytes (cmd outputs unchanged).
  - If rdy=1 in the same cycle the timeout would fire, the byte wins: it is captured and the timer clears.
- Bytes arriving while in CMD/RESP/TX states:
  - Not consumed (clr_rdy stays 0); they remain pending in the UART.
  - A pending byte is captured in the first RX0 cycle.
- The timer saturates and never wraps.

Decomposition:
- Shared package uart_seq_pkg holds:
  - state enum (RX0..WL) encoding;
  - FRAME_LEN=3;
  - RESP_LEN=2.
- One sub-module, frame_timer:
  - inputs: clear, enable;
  - parameters: TIMEOUT_CYC, TMR_W;
  - output: expired.
  - It contains the saturating counter.
- The FSM, tx_done edge detector and data registers stay in uart_cmd_seq.

Test Plan:
- Nominal frame:
  - Stimulus: bytes 0xA5, 0x12, 0x34 via rdy/rx_data.
  - Response: three single-cycle clr_rdy pulses; cmd_vld=1 with cmd_op=0xA5, cmd_data=0x1234 held until cmd_ack.
  - Then resp_vld with resp_data=0xBEEF.
  - Response: trmt with tx_data=0xBE; after a tx_done rise, trmt with tx_data=0xEF; after the second tx_done rise, busy=0.
- Timeout abort:
  - Stimulus: send 0x01, 0x02, then idle TIMEOUT_CYC cycles (bench uses TIMEOUT_CYC=20).
  - Response: frm_err single pulse, state RX0, no cmd_vld.
  - Then full frame 0x03, 0x04, 0x05: cmd_op=0x03, cmd_data=0x0405.
- Byte vs timeout collision: rdy asserted exactly on the expiry cycle -> byte captured, no frm_err, frame completes.
- Byte during response phase:
  - Stimulus: rdy=1 (0x77) held while in RESP/TX.
  - Response: clr_rdy stays 0; after WL completes, 0x77 is captured as the opcode of the next frame.
- Stale tx_done: tx_done held high throughout -> controller stays in WH until tx_done falls and rises again; no premature TXL.
- Async reset mid-TXH/WH:
  - Stimulus: rst pulse not aligned to clk.
  - Response: all outputs 0 immediately; after release, a fresh frame is processed normally.

Source files
------------

// File: rtl/uart_seq_pkg.sv
// Shared types and constants for the UART command/response sequencer.
package uart_seq_pkg;

    localparam int FRAME_LEN = 3;
    localparam int RESP_LEN  = 2;

    typedef enum logic [3:0] {
        RX0  = 4'd0,
        RX1  = 4'd1,
        RX2  = 4'd2,
        CMD  = 4'd3,
        RESP = 4'd4,
        TXH  = 4'd5,
        WH   = 4'd6,
        TXL  = 4'd7,
        WL   = 4'd8
    } state_t;

endpackage

// File: rtl/uart_cmd_seq_if.sv
// UART byte path plus host command/response handshake of the sequencer.
interface uart_cmd_seq_if;

    logic        rdy;
    logic [7:0]  rx_data;
    logic        clr_rdy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        cmd_vld;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        cmd_ack;
    logic        resp_vld;
    logic [15:0] resp_data;
    logic        frm_err;
    logic        busy;

    modport master (
        input  rdy, rx_data, tx_done, cmd_ack, resp_vld, resp_data,
        output clr_rdy, trmt, tx_data, cmd_vld, cmd_op, cmd_data, frm_err, busy
    );

    modport slave (
        output rdy, rx_data, tx_done, cmd_ack, resp_vld, resp_data,
        input  clr_rdy, trmt, tx_data, cmd_vld, cmd_op, cmd_data, frm_err, busy
    );

endinterface

// File: rtl/uart_cmd_seq_frame_timer.sv
// Inter-byte gap timer: saturating up-counter with a terminal-count flag.
module frame_timer #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TMR_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [TMR_W-1:0] cnt;

    // Holding at LAST keeps the counter from ever wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LAST)) begin
            cnt <= cnt + TMR_W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/uart_cmd_seq.sv
// Assembles 3-byte UART command frames for the host and returns its 16-bit
// response as two transmitted bytes, high byte first.
module uart_cmd_seq #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int TMR_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_seq_if.master  bus
);

    import uart_seq_pkg::*;

    // state | meaning
    // RX0   | idle, waiting for opcode byte
    // RX1   | waiting for data high byte (gap timed)
    // RX2   | waiting for data low byte (gap timed)
    // CMD   | frame presented, waiting for cmd_ack
    // RESP  | waiting for resp_vld
    // TXH   | launch high response byte
    // WH    | waiting for tx_done rise of high byte
    // TXL   | launch low response byte
    // WL    | waiting for tx_done rise of low byte

    state_t state, state_nxt;

    logic [7:0]  op_q;
    logic [7:0]  hi_q;
    logic [15:0] resp_q;
    logic        tx_done_q;

    logic        clr_rdy_q;
    logic        trmt_q;
    logic [7:0]  tx_data_q;
    logic        cmd_vld_q;
    logic [7:0]  cmd_op_q;
    logic [15:0] cmd_data_q;
    logic        frm_err_q;

    logic capture;
    logic in_gap;
    logic expired;
    logic timeout;
    logic tx_rise;

    // The clr_rdy term blanks rdy while the UART is still dropping it.
    assign capture = bus.rdy && !clr_rdy_q &&
                     ((state == RX0) || (state == RX1) || (state == RX2));
    assign in_gap  = (state == RX1) || (state == RX2);
    assign timeout = in_gap && expired && !capture;
    assign tx_rise = bus.tx_done && !tx_done_q;

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (capture),
        .enable  (in_gap),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX0:     if (capture) state_nxt = RX1;
            RX1:     if (capture) state_nxt = RX2;
                     else if (timeout) state_nxt = RX0;
            RX2:     if (capture) state_nxt = CMD;
                     else if (timeout) state_nxt = RX0;
            CMD:     if (bus.cmd_ack) state_nxt = RESP;
            RESP:    if (bus.resp_vld) state_nxt = TXH;
            TXH:     state_nxt = WH;
            WH:      if (tx_rise) state_nxt = TXL;
            TXL:     state_nxt = WL;
            WL:      if (tx_rise) state_nxt = RX0;
            default: state_nxt = RX0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            hi_q       <= '0;
            resp_q     <= '0;
            tx_done_q  <= 1'b0;
            clr_rdy_q  <= 1'b0;
            trmt_q     <= 1'b0;
            tx_data_q  <= '0;
            cmd_vld_q  <= 1'b0;
            cmd_op_q   <= '0;
            cmd_data_q <= '0;
            frm_err_q  <= 1'b0;
        end else begin
            tx_done_q <= bus.tx_done;
            clr_rdy_q <= capture;
            frm_err_q <= timeout;
            trmt_q    <= (state == TXH) || (state == TXL);

            if (capture && (state == RX0)) op_q <= bus.rx_data;
            if (capture && (state == RX1)) hi_q <= bus.rx_data;

            // Host-visible fields only change on a complete frame.
            if (capture && (state == RX2)) begin
                cmd_op_q   <= op_q;
                cmd_data_q <= {hi_q, bus.rx_data};
                cmd_vld_q  <= 1'b1;
            end else if ((state == CMD) && bus.cmd_ack) begin
                cmd_vld_q  <= 1'b0;
            end

            if ((state == RESP) && bus.resp_vld) resp_q <= bus.resp_data;

            if (state == TXH) tx_data_q <= resp_q[15:8];
            if (state == TXL) tx_data_q <= resp_q[7:0];
        end
    end

    assign bus.clr_rdy  = clr_rdy_q;
    assign bus.trmt     = trmt_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.cmd_vld  = cmd_vld_q;
    assign bus.cmd_op   = cmd_op_q;
    assign bus.cmd_data = cmd_data_q;
    assign bus.frm_err  = frm_err_q;
    assign bus.busy     = (state != RX0);

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Directed bench for uart_cmd_seq: table of nominal frames plus hand-written
// timeout, collision, pending-byte, stale tx_done and async-reset sequences.
module tb_uart_cmd_seq;

    localparam int TCYC = 20;

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [15:0] resp;
        int          ack_dly;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   total   = 0;
    int   bad     = 0;
    int   n_trmt  = 0;
    logic seen_clr = 1'b0;

    vec_t vecs[4];

    uart_cmd_seq_if bus();

    uart_cmd_seq #(
        .TIMEOUT_CYC (TCYC),
        .TMR_W       (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.trmt) n_trmt++;
        seen_clr = seen_clr | bus.clr_rdy;
    endtask

    // rdy stays high one cycle past clr_rdy, like a real UART clearing it late.
    task automatic send_byte(input logic [7:0] b);
        bus.rdy     = 1'b1;
        bus.rx_data = b;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.clr_rdy) break;
        end
        check("clr_rdy pulse", 32'(bus.clr_rdy), 32'd1);
        tick();
        check("clr_rdy single", 32'(bus.clr_rdy), 32'd0);
        bus.rdy = 1'b0;
    endtask

    task automatic wait_trmt(input string nm);
        for (int i = 0; i < 100; i++) begin
            if (bus.trmt) break;
            tick();
        end
        check(nm, 32'(bus.trmt), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            tick();
        end
        check("busy low at end", 32'(bus.busy), 32'd0);
    endtask

    task automatic pulse_tx_done();
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
    endtask

    task automatic do_ack(input int dly, input logic [7:0] op, input logic [15:0] data);
        repeat (dly) tick();
        check("cmd_vld held", 32'(bus.cmd_vld), 32'd1);
        check("cmd_op", 32'(bus.cmd_op), 32'(op));
        check("cmd_data", 32'(bus.cmd_data), 32'(data));
        bus.cmd_ack = 1'b1;
        tick();
        bus.cmd_ack = 1'b0;
        check("cmd_vld drop", 32'(bus.cmd_vld), 32'd0);
    endtask

    task automatic do_resp(input logic [15:0] resp);
        bus.resp_vld  = 1'b1;
        bus.resp_data = resp;
        tick();
        bus.resp_vld  = 1'b0;
        bus.resp_data = 16'h0000;
        wait_trmt("trmt high byte");
        check("tx_data high", 32'(bus.tx_data), 32'(resp[15:8]));
    endtask

    task automatic finish_tx(input logic [15:0] resp);
        tick();
        check("trmt single", 32'(bus.trmt), 32'd0);
        repeat (2) tick();
        pulse_tx_done();
        wait_trmt("trmt low byte");
        check("tx_data low", 32'(bus.tx_data), 32'(resp[7:0]));
        tick();
        check("tx_data hold", 32'(bus.tx_data), 32'(resp[7:0]));
        pulse_tx_done();
        wait_idle();
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'hA5, 8'h12, 8'h34, 16'hBEEF, 2};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 16'h0001, 0};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 16'h8000, 1};
        vecs[3] = '{8'h3C, 8'hC3, 8'h5A, 16'h00FF, 4};

        bus.rdy       = 1'b0;
        bus.rx_data   = 8'h00;
        bus.tx_done   = 1'b0;
        bus.cmd_ack   = 1'b0;
        bus.resp_vld  = 1'b0;
        bus.resp_data = 16'h0000;

        repeat (2) tick();
        check("reset ctl", 32'({bus.clr_rdy, bus.trmt, bus.tx_data, bus.cmd_vld,
                                bus.frm_err, bus.busy}), 32'd0);
        check("reset cmd", 32'({bus.cmd_op, bus.cmd_data}), 32'd0);
        rst = 1'b0;
        tick();

        // Nominal frames from the table.
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].op, vecs[v].hi, vecs[v].lo);
            check("cmd_vld rise", 32'(bus.cmd_vld), 32'd1);
            do_ack(vecs[v].ack_dly, vecs[v].op, {vecs[v].hi, vecs[v].lo});
            do_resp(vecs[v].resp);
            finish_tx(vecs[v].resp);
        end

        // Timeout: send_byte returns one cycle after clr_rdy, timer at 1.
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (TCYC - 2) tick();
        check("frm_err early", 32'(bus.frm_err), 32'd0);
        check("busy before timeout", 32'(bus.busy), 32'd1);
        tick();
        check("frm_err pulse", 32'(bus.frm_err), 32'd1);
        check("busy after timeout", 32'(bus.busy), 32'd0);
        tick();
        check("frm_err single", 32'(bus.frm_err), 32'd0);
        check("no cmd_vld after timeout", 32'(bus.cmd_vld), 32'd0);
        check("cmd_op unchanged", 32'(bus.cmd_op), 32'(vecs[3].op));
        send_frame(8'h03, 8'h04, 8'h05);
        do_ack(1, 8'h03, 16'h0405);
        do_resp(16'h1234);
        finish_tx(16'h1234);

        // Byte arrives on the exact expiry cycle: the byte must win.
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TCYC - 2) tick();
        bus.rdy     = 1'b1;
        bus.rx_data = 8'h33;
        tick();
        check("collision clr_rdy", 32'(bus.clr_rdy), 32'd1);
        check("collision frm_err", 32'(bus.frm_err), 32'd0);
        tick();
        bus.rdy = 1'b0;
        check("collision frm_err late", 32'(bus.frm_err), 32'd0);
        do_ack(0, 8'h11, 16'h2233);
        do_resp(16'h5566);
        finish_tx(16'h5566);

        // Byte pending during RESP/TX must wait for RX0.
        send_frame(8'h40, 8'h41, 8'h42);
        do_ack(1, 8'h40, 16'h4142);
        bus.rdy     = 1'b1;
        bus.rx_data = 8'h77;
        seen_clr    = 1'b0;
        do_resp(16'h1111);
        finish_tx(16'h1111);
        check("no consume while busy", 32'(seen_clr), 32'd0);
        tick();
        check("pending byte captured", 32'(bus.clr_rdy), 32'd1);
        tick();
        bus.rdy = 1'b0;
        send_byte(8'h78);
        send_byte(8'h79);
        do_ack(0, 8'h77, 16'h7879);
        do_resp(16'h2222);
        finish_tx(16'h2222);

        // tx_done already high when WH is entered must not count as done.
        send_frame(8'hC0, 8'hC1, 8'hC2);
        do_ack(0, 8'hC0, 16'hC1C2);
        bus.tx_done = 1'b1;
        do_resp(16'hCAFE);
        n_trmt = 0;
        repeat (10) tick();
        check("stale tx_done no trmt", 32'(n_trmt), 32'd0);
        check("stale busy", 32'(bus.busy), 32'd1);
        check("stale tx_data", 32'(bus.tx_data), 32'h0000_00CA);
        bus.tx_done = 1'b0;
        tick();
        bus.tx_done = 1'b1;
        tick();
        wait_trmt("trmt after fresh rise");
        check("stale tx_data low", 32'(bus.tx_data), 32'h0000_00FE);
        tick();
        bus.tx_done = 1'b0;
        tick();
        pulse_tx_done();
        wait_idle();

        // Asynchronous reset while trmt is high in WH.
        send_frame(8'h5A, 8'h00, 8'hFF);
        do_ack(2, 8'h5A, 16'h00FF);
        do_resp(16'h1357);
        #2;
        rst = 1'b1;
        #1;
        check("async reset ctl", 32'({bus.clr_rdy, bus.trmt, bus.tx_data, bus.cmd_vld,
                                      bus.frm_err, bus.busy}), 32'd0);
        check("async reset cmd", 32'({bus.cmd_op, bus.cmd_data}), 32'd0);
        #3;
        rst = 1'b0;
        tick();
        check("idle after reset", 32'(bus.busy), 32'd0);
        send_frame(8'h66, 8'h67, 8'h68);
        do_ack(1, 8'h66, 16'h6768);
        do_resp(16'h9ABC);
        finish_tx(16'h9ABC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
